fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, program-counter width.
REQ-002 The block SHALL have parameter IWIDTH, default 32, instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 The block SHALL have port fs_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port fs_rst, input, 1, reset; synchronous, active-high.
REQ-006 The block SHALL have port fs_o_imem_req, output, 1, instruction-memory read request.
REQ-007 The block SHALL have port fs_o_imem_addr, output, PC_WIDTH, instruction-memory read address.
REQ-008 The block SHALL have port fs_i_imem_ack, input, 1, read data valid this cycle.
REQ-009 The block SHALL have port fs_i_imem_instr, input, IWIDTH, read data.
REQ-010 The block SHALL have port fs_i_change_pc, input, 1, redirect request from execute.
REQ-011 The block SHALL have port fs_i_new_pc, input, PC_WIDTH, redirect target.
REQ-012 The block SHALL have port fs_i_stall, input, 1, decoder cannot accept.
REQ-013 The block SHALL have port fs_i_flush, input, 1, kill in-flight instruction.
REQ-014 The block SHALL have port fs_o_instr, output, IWIDTH, registered instruction to the decoder.
REQ-015 The block SHALL have port fs_o_pc, output, PC_WIDTH, PC of fs_o_instr.
REQ-016 The block SHALL have port fs_o_ce, output, 1, fs_o_instr/fs_o_pc valid.

Function
REQ-017 The block SHALL implement an FSM with states IDLE, FETCH and HOLD, plus a PC register, a one-entry skid buffer (instr, pc, valid) and output registers.
REQ-018 fs_o_imem_req SHALL be 1 only in FETCH; fs_o_imem_addr SHALL equal the PC register and stay stable until ack, redirect or flush.
REQ-019 IDLE SHALL last exactly one cycle, then enter FETCH.
REQ-020 FETCH, ack=1, stall=0: on the next edge fs_o_instr<=data, fs_o_pc<=PC, fs_o_ce<=1, PC<=PC+4; state stays FETCH (latency ack->output is 1 cycle).
REQ-021 FETCH, ack=1, stall=1: data and PC SHALL be captured in the skid buffer, PC<=PC+4, state->HOLD; output registers hold.
REQ-022 FETCH, ack=0: fs_o_ce SHALL become 0 if stall=0, or hold if stall=1; PC unchanged.
REQ-023 HOLD: req=0; while stall=1 outputs and buffer hold; when stall=0, outputs<=buffer, fs_o_ce<=1, buffer invalid, state->FETCH.
REQ-024 fs_i_change_pc=1 SHALL give PC<=fs_i_new_pc, buffer invalid, fs_o_ce<=0, state->IDLE, discarding any same-cycle ack; the IDLE cycle drops req so memory aborts the stale access.
REQ-025 fs_i_flush=1 without redirect SHALL give fs_o_ce<=0, buffer invalid, state->FETCH, PC unchanged.
REQ-026 Priority SHALL be reset > change_pc > flush > stall > ack.
REQ-027 PC+4 SHALL wrap modulo 2^PC_WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-028 fs_i_new_pc[1:0] SHALL be forced to 00 when loaded.

Reset
REQ-029 When fs_rst=1 at an edge: state<=IDLE, PC<=RESET_PC, buffer invalid, fs_o_ce<=0, fs_o_instr<=0, fs_o_pc<=0; fs_o_imem_req is 0 while in IDLE.
REQ-030 Reset mid-access or mid-HOLD SHALL discard the pending instruction; the first request after reset SHALL go to RESET_PC.

Structure
REQ-031 The shared package/header SHALL hold the FSM state encodings and the PC increment constant (4); the rest is local.
REQ-032 The skid buffer SHALL be a sub-module fetch_skid_buffer (load/clear/valid); the FSM and PC stay in fetch_stage.

Verification
REQ-033 Reset, then ack every cycle with instr=0x00310093 -> req in cycle 2; fs_o_pc 0,4,8 on consecutive cycles with fs_o_ce=1.
REQ-034 Stall=1 in the ack cycle of PC=8, held 3 cycles -> HOLD, req=0, outputs frozen at PC=4; after release fs_o_pc=8, then fetch resumes at 12.
REQ-035 change_pc=1, new_pc=0x103 in the same cycle as an ack -> ack discarded, fs_o_ce=0, one IDLE cycle, next address 0x100.
REQ-036 flush=1 and stall=1 together while in HOLD -> fs_o_ce=0, buffer cleared, FETCH resumes at the current PC.
REQ-037 RESET_PC=0xFFFFFFF8 with acks -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 fs_rst=1 while in HOLD -> next cycle fs_o_ce=0, buffer invalid, first request after reset at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings and PC step.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory port, execute redirect, decoder handshake.
interface fetch_stage_if #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
);
  logic                fs_o_imem_req;
  logic [PC_WIDTH-1:0] fs_o_imem_addr;
  logic                fs_i_imem_ack;
  logic [IWIDTH-1:0]   fs_i_imem_instr;
  logic                fs_i_change_pc;
  logic [PC_WIDTH-1:0] fs_i_new_pc;
  logic                fs_i_stall;
  logic                fs_i_flush;
  logic [IWIDTH-1:0]   fs_o_instr;
  logic [PC_WIDTH-1:0] fs_o_pc;
  logic                fs_o_ce;

  modport master (
    output fs_o_imem_req, fs_o_imem_addr, fs_o_instr, fs_o_pc, fs_o_ce,
    input  fs_i_imem_ack, fs_i_imem_instr, fs_i_change_pc, fs_i_new_pc,
           fs_i_stall, fs_i_flush
  );

  modport slave (
    input  fs_o_imem_req, fs_o_imem_addr, fs_o_instr, fs_o_pc, fs_o_ce,
    output fs_i_imem_ack, fs_i_imem_instr, fs_i_change_pc, fs_i_new_pc,
           fs_i_stall, fs_i_flush
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction returned while the decoder stalls.
module fetch_skid_buffer #(
  parameter int PC_WIDTH = 32,
  parameter int IWIDTH   = 32
) (
  input  logic                fs_clk,
  input  logic                fs_rst,
  input  logic                load,
  input  logic                clear,
  input  logic [IWIDTH-1:0]   d_instr,
  input  logic [PC_WIDTH-1:0] d_pc,
  output logic [IWIDTH-1:0]   q_instr,
  output logic [PC_WIDTH-1:0] q_pc,
  output logic                valid
);

  // Payload needs no reset: it is only observed while valid is set.
  always_ff @(posedge fs_clk) begin
    if (fs_rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      q_instr <= d_instr;
      q_pc    <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, memory request, decoder handoff with stall/redirect/flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  IWIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input logic           fs_clk,
  input logic           fs_rst,
  fetch_stage_if.master fs
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic                buf_load, buf_clear, buf_valid;
  logic [IWIDTH-1:0]   buf_instr;
  logic [PC_WIDTH-1:0] buf_pc;

  assign fs.fs_o_imem_req  = (state == ST_FETCH);
  assign fs.fs_o_imem_addr = pc;
  assign pc_next           = pc + PC_WIDTH'(PC_INC);

  // Park the returned word only when nothing of higher priority overrides the ack.
  assign buf_load  = !fs.fs_i_change_pc && !fs.fs_i_flush && (state == ST_FETCH)
                   && fs.fs_i_imem_ack && fs.fs_i_stall;
  assign buf_clear = fs.fs_i_change_pc || fs.fs_i_flush
                   || ((state == ST_HOLD) && !fs.fs_i_stall);

  fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH), .IWIDTH(IWIDTH)) u_skid (
    .fs_clk  (fs_clk),
    .fs_rst  (fs_rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .d_instr (fs.fs_i_imem_instr),
    .d_pc    (pc),
    .q_instr (buf_instr),
    .q_pc    (buf_pc),
    .valid   (buf_valid)
  );

  always_ff @(posedge fs_clk) begin
    if (fs_rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      fs.fs_o_ce    <= 1'b0;
      fs.fs_o_instr <= '0;
      fs.fs_o_pc    <= '0;
    end else if (fs.fs_i_change_pc) begin
      // IDLE drops req for a cycle so memory abandons the stale access.
      state      <= ST_IDLE;
      pc         <= {fs.fs_i_new_pc[PC_WIDTH-1:2], 2'b00};
      fs.fs_o_ce <= 1'b0;
    end else if (fs.fs_i_flush) begin
      state      <= ST_FETCH;
      fs.fs_o_ce <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (fs.fs_i_imem_ack) begin
            pc <= pc_next;
            if (fs.fs_i_stall) begin
              state <= ST_HOLD;
            end else begin
              fs.fs_o_instr <= fs.fs_i_imem_instr;
              fs.fs_o_pc    <= pc;
              fs.fs_o_ce    <= 1'b1;
            end
          end else if (!fs.fs_i_stall) begin
            fs.fs_o_ce <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!fs.fs_i_stall) begin
            fs.fs_o_instr <= buf_instr;
            fs.fs_o_pc    <= buf_pc;
            fs.fs_o_ce    <= buf_valid;
            state         <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: main DUT at RESET_PC=0, second at 0xFFFFFFF8.
module tb_fetch_stage;

  localparam int PW = 32;
  localparam int IW = 32;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
  } exp_t;

  logic fs_clk = 1'b0;
  logic rst_a, rst_b;
  logic mem_en;
  logic [IW-1:0] mem_data;
  int n_vec = 0;
  int n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 fs_clk = ~fs_clk;

  fetch_stage_if #(.PC_WIDTH(PW), .IWIDTH(IW)) ia ();
  fetch_stage_if #(.PC_WIDTH(PW), .IWIDTH(IW)) ib ();

  fetch_stage #(.PC_WIDTH(PW), .IWIDTH(IW), .RESET_PC(32'h0000_0000)) dut_a (
    .fs_clk (fs_clk),
    .fs_rst (rst_a),
    .fs     (ia)
  );

  fetch_stage #(.PC_WIDTH(PW), .IWIDTH(IW), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .fs_clk (fs_clk),
    .fs_rst (rst_b),
    .fs     (ib)
  );

  // Zero-wait memory: acknowledges any request in the same cycle when enabled.
  assign ia.fs_i_imem_ack   = mem_en & ia.fs_o_imem_req;
  assign ia.fs_i_imem_instr = mem_data;
  assign ib.fs_i_imem_ack   = ib.fs_o_imem_req;
  assign ib.fs_i_imem_instr = 32'h0000_0013;
  assign ib.fs_i_change_pc  = 1'b0;
  assign ib.fs_i_new_pc     = '0;
  assign ib.fs_i_stall      = 1'b0;
  assign ib.fs_i_flush      = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge fs_clk);
    #1;
  endtask

  // An output is consumed when it is valid and the decoder is not stalling.
  always @(negedge fs_clk) begin
    if (ia.fs_o_ce === 1'b1 && ia.fs_i_stall === 1'b0) begin
      exp_t e;
      if (qa.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL mon_a_extra: got pc %0h, expected none", ia.fs_o_pc);
      end else begin
        e = qa.pop_front();
        chk("mon_a_pc", 64'(ia.fs_o_pc), 64'(e.pc));
        chk("mon_a_instr", 64'(ia.fs_o_instr), 64'(e.instr));
      end
    end
  end

  always @(negedge fs_clk) begin
    if (ib.fs_o_ce === 1'b1) begin
      exp_t e;
      if (qb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL mon_b_extra: got pc %0h, expected none", ib.fs_o_pc);
      end else begin
        e = qb.pop_front();
        chk("mon_b_pc", 64'(ib.fs_o_pc), 64'(e.pc));
        chk("mon_b_instr", 64'(ib.fs_o_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    mem_en = 1'b1;
    mem_data = 32'h0031_0093;
    ia.fs_i_change_pc = 1'b0;
    ia.fs_i_new_pc = '0;
    ia.fs_i_flush = 1'b0;
    ia.fs_i_stall = 1'b0;
    cyc(2);
    chk("rst_ce", 64'(ia.fs_o_ce), 64'd0);
    chk("rst_instr", 64'(ia.fs_o_instr), 64'd0);
    chk("rst_pc", 64'(ia.fs_o_pc), 64'd0);
    chk("rst_req", 64'(ia.fs_o_imem_req), 64'd0);

    // Straight-line fetch, then a 3-cycle stall landing on PC=8.
    rst_a = 1'b0;
    chk("idle_req", 64'(ia.fs_o_imem_req), 64'd0);
    qa.push_back('{32'h0031_0093, 32'h0});
    qa.push_back('{32'h0031_0093, 32'h4});
    qa.push_back('{32'h0031_0093, 32'h8});
    qa.push_back('{32'h0031_0093, 32'hC});
    cyc();
    chk("c2_req", 64'(ia.fs_o_imem_req), 64'd1);
    chk("c2_addr", 64'(ia.fs_o_imem_addr), 64'h0);
    cyc();
    chk("c3_ce", 64'(ia.fs_o_ce), 64'd1);
    chk("c3_pc", 64'(ia.fs_o_pc), 64'h0);
    chk("c3_addr", 64'(ia.fs_o_imem_addr), 64'h4);
    cyc();
    chk("c4_pc", 64'(ia.fs_o_pc), 64'h4);
    ia.fs_i_stall = 1'b1;
    cyc();
    chk("hold_req", 64'(ia.fs_o_imem_req), 64'd0);
    chk("hold_pc", 64'(ia.fs_o_pc), 64'h4);
    chk("hold_ce", 64'(ia.fs_o_ce), 64'd1);
    cyc(2);
    chk("hold3_pc", 64'(ia.fs_o_pc), 64'h4);
    chk("hold3_req", 64'(ia.fs_o_imem_req), 64'd0);
    ia.fs_i_stall = 1'b0;
    cyc();
    chk("rel_pc", 64'(ia.fs_o_pc), 64'h8);
    chk("rel_ce", 64'(ia.fs_o_ce), 64'd1);
    chk("rel_addr", 64'(ia.fs_o_imem_addr), 64'hC);
    cyc();
    chk("resume_pc", 64'(ia.fs_o_pc), 64'hC);

    // Redirect alongside an ack to 0x10: ack dropped, misaligned target rounded.
    ia.fs_i_change_pc = 1'b1;
    ia.fs_i_new_pc = 32'h0000_0103;
    cyc();
    chk("redir_ce", 64'(ia.fs_o_ce), 64'd0);
    chk("redir_req", 64'(ia.fs_o_imem_req), 64'd0);
    ia.fs_i_change_pc = 1'b0;
    qa.push_back('{32'h0031_0093, 32'h100});
    cyc();
    chk("redir_addr", 64'(ia.fs_o_imem_addr), 64'h100);
    chk("redir_req2", 64'(ia.fs_o_imem_req), 64'd1);
    cyc();
    chk("redir_out", 64'(ia.fs_o_pc), 64'h100);
    cyc();
    chk("c12_pc", 64'(ia.fs_o_pc), 64'h104);

    // Enter HOLD with 0x108 buffered, then flush while still stalled.
    ia.fs_i_stall = 1'b1;
    cyc();
    chk("h2_req", 64'(ia.fs_o_imem_req), 64'd0);
    chk("h2_pc", 64'(ia.fs_o_pc), 64'h104);
    ia.fs_i_flush = 1'b1;
    cyc();
    chk("flush_ce", 64'(ia.fs_o_ce), 64'd0);
    chk("flush_req", 64'(ia.fs_o_imem_req), 64'd1);
    chk("flush_addr", 64'(ia.fs_o_imem_addr), 64'h10C);
    ia.fs_i_flush = 1'b0;
    ia.fs_i_stall = 1'b0;
    qa.push_back('{32'h0031_0093, 32'h10C});
    qa.push_back('{32'h0031_0093, 32'h110});
    cyc();
    chk("postflush_pc", 64'(ia.fs_o_pc), 64'h10C);
    cyc(2);
    chk("c17_pc", 64'(ia.fs_o_pc), 64'h114);

    // Reset while in HOLD: buffered 0x118 must vanish, restart at RESET_PC.
    ia.fs_i_stall = 1'b1;
    cyc();
    chk("h3_req", 64'(ia.fs_o_imem_req), 64'd0);
    rst_a = 1'b1;
    cyc();
    chk("hrst_ce", 64'(ia.fs_o_ce), 64'd0);
    chk("hrst_pc", 64'(ia.fs_o_pc), 64'h0);
    chk("hrst_instr", 64'(ia.fs_o_instr), 64'h0);
    chk("hrst_req", 64'(ia.fs_o_imem_req), 64'd0);
    rst_a = 1'b0;
    ia.fs_i_stall = 1'b0;
    mem_data = 32'h0000_0013;
    qa.push_back('{32'h0000_0013, 32'h0});
    qa.push_back('{32'h0000_0013, 32'h4});
    cyc();
    chk("rr_req", 64'(ia.fs_o_imem_req), 64'd1);
    chk("rr_addr", 64'(ia.fs_o_imem_addr), 64'h0);
    cyc();
    chk("rr_pc0", 64'(ia.fs_o_pc), 64'h0);
    cyc();
    chk("rr_pc4", 64'(ia.fs_o_pc), 64'h4);

    // No ack, no stall: valid drops and the address holds.
    mem_en = 1'b0;
    cyc();
    chk("noack_ce", 64'(ia.fs_o_ce), 64'd0);
    chk("noack_addr", 64'(ia.fs_o_imem_addr), 64'h8);

    // PC wrap on the high-reset instance.
    rst_b = 1'b0;
    qb.push_back('{32'h0000_0013, 32'hFFFF_FFF8});
    qb.push_back('{32'h0000_0013, 32'hFFFF_FFFC});
    qb.push_back('{32'h0000_0013, 32'h0000_0000});
    cyc();
    chk("b_addr0", 64'(ib.fs_o_imem_addr), 64'hFFFF_FFF8);
    cyc();
    chk("b_addr1", 64'(ib.fs_o_imem_addr), 64'hFFFF_FFFC);
    cyc();
    chk("b_addr2", 64'(ib.fs_o_imem_addr), 64'h0);
    cyc();
    rst_b = 1'b1;
    cyc(2);

    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
